tank_ctrl: RTL

Parametrised per-frame tank motion controller. It decodes a 4-byte USB keycode word into independent drive and rotate commands, and integrates heading-dependent motion in fixed point. It keeps position inside a configurable arena and exports position, size, heading index and status flags. It sits between the USB keycode register and the sprite/bullet logic, one instance per player. Heading sin/cos come from the shared external LUT, addressed by this block's `Angle` output.

---
 rtl/tank_pkg.sv | 77 +++++++
 rtl/tank_key_decode.sv | 48 ++++
 rtl/tank_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared types, key codes, Q-format constants and the per-axis limit helper for tank_ctrl.
// Latency: n/a (declarations plus one pure function).
// Backpressure: n/a.
// Macro TANK_CTRL_WRAP_EN: clamp_axis wraps toroidally instead of saturating.
package tank_pkg;

    // Default key codes (USB HID usage IDs for the arrow keys)
    localparam logic [7:0] KEY_FWD_DEF  = 8'h52;
    localparam logic [7:0] KEY_BACK_DEF = 8'h51;
    localparam logic [7:0] KEY_CCW_DEF  = 8'h50;
    localparam logic [7:0] KEY_CW_DEF   = 8'h4F;

    // Position format: Q10.6 unsigned per axis; candidates carry one extra sign bit
    localparam int FRAC_W = 6;
    localparam int POS_W  = 16;
    localparam int CAND_W = POS_W + 1;

    typedef enum logic [1:0] {
        DRV_NONE = 2'd0,
        DRV_FWD  = 2'd1,
        DRV_BACK = 2'd2
    } drv_e;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CCW  = 2'd1,
        ROT_CW   = 2'd2
    } rot_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rot_state_e;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             hit;
    } axis_t;

    // Limit one candidate axis to [lo, hi] on its integer part.
    // Saturating build snaps to the wall with a zero fraction; wrap build
    // jumps to the opposite wall and keeps the fraction.
    function automatic axis_t clamp_axis(
        input logic signed [CAND_W-1:0] cand,
        input int                       lo,
        input int                       hi
    );
        axis_t                    r;
        logic signed [CAND_W-1:0] ip_v;
        int                       ip;
        logic [9:0]               lo_i;
        logic [9:0]               hi_i;
        ip_v  = cand >>> FRAC_W;
        ip    = int'(ip_v);
        lo_i  = 10'(lo);
        hi_i  = 10'(hi);
        r.pos = cand[POS_W-1:0];
        r.hit = 1'b0;
        if (ip < lo) begin
`ifdef TANK_CTRL_WRAP_EN
            r.pos = {hi_i, cand[FRAC_W-1:0]};
`else
            r.pos = {lo_i, {FRAC_W{1'b0}}};
`endif
            r.hit = 1'b1;
        end else if (ip > hi) begin
`ifdef TANK_CTRL_WRAP_EN
            r.pos = {lo_i, cand[FRAC_W-1:0]};
`else
            r.pos = {hi_i, {FRAC_W{1'b0}}};
`endif
            r.hit = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tank_key_decode.sv
// Scans four keycode bytes into independent drive and rotate commands (FWD > BACK, CCW > CW).
// Latency: combinational.
// Backpressure: none; a new decode every frame.
// Ports: keycode (4 bytes, 0x00 = empty) in; drv, rot out.
module tank_key_decode
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD  = KEY_FWD_DEF,
    parameter logic [7:0] KEY_BACK = KEY_BACK_DEF,
    parameter logic [7:0] KEY_CCW  = KEY_CCW_DEF,
    parameter logic [7:0] KEY_CW   = KEY_CW_DEF
) (
    input  logic [31:0] keycode,
    output drv_e        drv,
    output rot_e        rot
);

    logic fwd_hit;
    logic back_hit;
    logic ccw_hit;
    logic cw_hit;

    always_comb begin
        fwd_hit  = 1'b0;
        back_hit = 1'b0;
        ccw_hit  = 1'b0;
        cw_hit   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // An empty slot never matches, even if a key code parameter is 0
            if (keycode[8*i +: 8] != 8'h00) begin
                if (keycode[8*i +: 8] == KEY_FWD)  fwd_hit  = 1'b1;
                if (keycode[8*i +: 8] == KEY_BACK) back_hit = 1'b1;
                if (keycode[8*i +: 8] == KEY_CCW)  ccw_hit  = 1'b1;
                if (keycode[8*i +: 8] == KEY_CW)   cw_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        drv = DRV_NONE;
        rot = ROT_NONE;
        if (fwd_hit)       drv = DRV_FWD;
        else if (back_hit) drv = DRV_BACK;
        if (ccw_hit)       rot = ROT_CCW;
        else if (cw_hit)   rot = ROT_CW;
    end

endmodule

// File: rtl/tank_ctrl.sv
// Per-frame tank motion: registered key decode, rate-limited heading steps, Q10.6 position with arena limits.
// Latency: key sampled at edge k, heading/position change at edge k+1 (2 edges key-to-output).
// Backpressure: none; one update per frame_clk edge, inputs always accepted.
// Ports: frame_clk, Reset (async, active-high), keycode[31:0], sin/cos (Q1.7 for Angle) in;
//        BallX/BallY/BallS[9:0], Angle, moving, blocked out.
// Macro TANK_CTRL_WRAP_EN: toroidal arena instead of clamping at the walls.
module tank_ctrl
    import tank_pkg::*;
#(
    parameter int         X_CENTER = 300,
    parameter int         Y_CENTER = 250,
    parameter int         X_MIN    = 0,
    parameter int         X_MAX    = 639,
    parameter int         Y_MIN    = 0,
    parameter int         Y_MAX    = 479,
    parameter int         SIZE     = 10,
    parameter logic [7:0] STEP     = 8'd128,
    parameter int         N_ANGLES = 45,
    parameter int         ROT_DIV  = 2,
    parameter logic [7:0] KEY_FWD  = KEY_FWD_DEF,
    parameter logic [7:0] KEY_BACK = KEY_BACK_DEF,
    parameter logic [7:0] KEY_CCW  = KEY_CCW_DEF,
    parameter logic [7:0] KEY_CW   = KEY_CW_DEF
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic [31:0]                 keycode,
    input  logic signed [7:0]           sin,
    input  logic signed [7:0]           cos,
    output logic [9:0]                  BallX,
    output logic [9:0]                  BallY,
    output logic [9:0]                  BallS,
    output logic [$clog2(N_ANGLES)-1:0] Angle,
    output logic                        moving,
    output logic                        blocked
);

    localparam int                AW         = $clog2(N_ANGLES);
    localparam int                CNT_W      = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
    localparam logic [AW-1:0]     ANG_LAST   = AW'(N_ANGLES - 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(ROT_DIV - 1);
    localparam logic [POS_W-1:0]  X_RST      = POS_W'(X_CENTER * (1 << FRAC_W));
    localparam logic [POS_W-1:0]  Y_RST      = POS_W'(Y_CENTER * (1 << FRAC_W));
    localparam logic signed [CAND_W-1:0] STEP_S = {{(CAND_W-8){1'b0}}, STEP};

    // ---------------- key decode and sample ----------------
    drv_e drv_d;
    drv_e drv_q;
    rot_e rot_d;
    rot_e rot_q;

    tank_key_decode #(
        .KEY_FWD  (KEY_FWD),
        .KEY_BACK (KEY_BACK),
        .KEY_CCW  (KEY_CCW),
        .KEY_CW   (KEY_CW)
    ) u_key_decode (
        .keycode (keycode),
        .drv     (drv_d),
        .rot     (rot_d)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            drv_q <= DRV_NONE;
            rot_q <= ROT_NONE;
        end else begin
            drv_q <= drv_d;
            rot_q <= rot_d;
        end
    end

    // ---------------- rotation FSM ----------------
    rot_state_e       state_q;
    rot_state_e       state_d;
    logic [CNT_W-1:0] rot_cnt;
    logic [AW-1:0]    angle_q;
    logic             rot_step;
    logic             cnt_dec;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state_q <= R_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (rot_q != ROT_NONE) state_d = R_HOLD;
            R_HOLD:  if (rot_q == ROT_NONE) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // Step on the first held frame, then every ROT_DIV frames. The counter
    // is not reloaded on a direction change, so a reversal keeps the cadence.
    always_comb begin
        rot_step = 1'b0;
        cnt_dec  = 1'b0;
        if (rot_q != ROT_NONE) begin
            if (state_q == R_IDLE || rot_cnt == '0) rot_step = 1'b1;
            else                                     cnt_dec  = 1'b1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rot_cnt <= '0;
            angle_q <= '0;
        end else begin
            if (rot_step) begin
                rot_cnt <= CNT_RELOAD;
                if (rot_q == ROT_CCW) angle_q <= (angle_q == ANG_LAST) ? '0 : angle_q + 1'b1;
                else                  angle_q <= (angle_q == '0) ? ANG_LAST : angle_q - 1'b1;
            end else if (cnt_dec) begin
                rot_cnt <= rot_cnt - 1'b1;
            end
        end
    end

    // ---------------- motion ----------------
    logic [POS_W-1:0]         x_q;
    logic [POS_W-1:0]         y_q;
    logic                     moving_q;
    logic                     blocked_q;
    logic signed [CAND_W-1:0] cos_s;
    logic signed [CAND_W-1:0] sin_s;
    logic signed [CAND_W-1:0] prod_x;
    logic signed [CAND_W-1:0] prod_y;
    logic signed [CAND_W-1:0] dx;
    logic signed [CAND_W-1:0] dy;
    logic signed [CAND_W-1:0] x_ext;
    logic signed [CAND_W-1:0] y_ext;
    logic signed [CAND_W-1:0] x_cand;
    logic signed [CAND_W-1:0] y_cand;
    axis_t                    x_ax;
    axis_t                    y_ax;

    assign cos_s  = {{(CAND_W-8){cos[7]}}, cos};
    assign sin_s  = {{(CAND_W-8){sin[7]}}, sin};
    // |STEP*trig| <= 32640, so 17-bit signed products cannot overflow
    assign prod_x = STEP_S * cos_s;
    assign prod_y = STEP_S * sin_s;
    assign dx     = prod_x >>> 7;
    assign dy     = prod_y >>> 7;
    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};

    // Screen Y grows downward, so forward motion subtracts the sine term
    always_comb begin
        x_cand = x_ext;
        y_cand = y_ext;
        case (drv_q)
            DRV_FWD: begin
                x_cand = x_ext + dx;
                y_cand = y_ext - dy;
            end
            DRV_BACK: begin
                x_cand = x_ext - dx;
                y_cand = y_ext + dy;
            end
            default: ;
        endcase
    end

    assign x_ax = clamp_axis(x_cand, X_MIN + SIZE, X_MAX - SIZE);
    assign y_ax = clamp_axis(y_cand, Y_MIN + SIZE, Y_MAX - SIZE);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            x_q       <= X_RST;
            y_q       <= Y_RST;
            moving_q  <= 1'b0;
            blocked_q <= 1'b0;
        end else if (drv_q != DRV_NONE) begin
            x_q       <= x_ax.pos;
            y_q       <= y_ax.pos;
            moving_q  <= 1'b1;
            blocked_q <= x_ax.hit | y_ax.hit;
        end else begin
            moving_q  <= 1'b0;
            blocked_q <= 1'b0;
        end
    end

    assign BallX   = x_q[POS_W-1:FRAC_W];
    assign BallY   = y_q[POS_W-1:FRAC_W];
    assign BallS   = 10'(SIZE);
    assign Angle   = angle_q;
    assign moving  = moving_q;
    assign blocked = blocked_q;

endmodule
